dma_csr: RTL and testbench
==========================

DMA_CSR -- requirements
Module: dma_csr

Interface
REQ-001 Parameter ADDR_LSB_BITS, default 5, number of S_AWADDR/S_ARADDR bits decoded (bits [4:2] select the register).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, exposed as the ports below.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- S_AWADDR  in  32  write address; S_AWVALID in 1; S_AWREADY out 1
- S_WDATA  in  32; S_WSTRB in 4; S_WVALID in 1; S_WREADY out 1
- S_BRESP  out  2; S_BVALID out 1; S_BREADY in 1
- S_ARADDR  in  32; S_ARVALID in 1; S_ARREADY out 1
- S_RDATA  out  32; S_RRESP out 2; S_RVALID out 1; S_RREADY in 1
- trigger  out  1  one-cycle start pulse to the DMA controller
- source_address  out  32; destination_address out 32; length out 5  (the DMA job descriptor)
- dma_done  in  1  DMA controller DONE level (held until the next trigger)
- irq  out  1  level interrupt

Function
REQ-003 Register map (byte offsets):
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 REJECT (sticky, W1C).
- 0x08 SRC (RW 32); 0x0C DST (RW 32); 0x10 LEN (RW, bits [4:0]; bits [31:5] read 0).
- 0x14 to 0x1C: unmapped.
REQ-004 Address decoding SHALL use ADDR[4:2] only; ADDR[1:0] and ADDR[31:5] are ignored.
REQ-005 The AW and W channels SHALL be accepted independently.
- S_AWREADY is high when no address is held and S_BVALID is low.
- S_WREADY is high when no data is held and S_BVALID is low.
REQ-006 Commit occurs on the first cycle in which both AW and W are held.
- At the next edge: the register updates, S_BVALID rises, and both holds clear.
REQ-007 S_BVALID and S_BRESP SHALL stay stable until S_BREADY is sampled high, then S_BVALID drops at that edge.
REQ-008 Byte strobes SHALL gate each byte lane independently.
- LEN uses lane 0 only.
- CTRL and STATUS act only when lane 0 is strobed.
REQ-009 BRESP SHALL be OKAY (2'b00), except SLVERR (2'b10) with no state change for:
- an unmapped address;
- a write to SRC, DST or LEN while BUSY=1.
REQ-010 A commit writing CTRL.START=1 while BUSY=0 SHALL, at the same edge as the register update:
- drive trigger high for exactly one cycle;
- set BUSY=1.
REQ-011 A commit writing START=1 while BUSY=1 SHALL:
- produce no trigger;
- set REJECT=1;
- return BRESP OKAY.
REQ-012 A rising edge of dma_done SHALL clear BUSY and set DONE at the next edge.
- The edge is detected against a registered copy of dma_done, which resets to 0.
REQ-013 If a DONE or REJECT set event coincides with a W1C of the same bit, the set SHALL win.
REQ-014 Writing 1 to STATUS.BUSY SHALL have no effect.
REQ-015 irq SHALL equal IRQ_EN AND DONE, driven from registers (no combinational path from inputs).
REQ-016 The read channel:
- S_ARREADY is high when S_RVALID is low.
- On an AR handshake, S_RDATA and S_RRESP are registered and S_RVALID rises at the next edge.
- S_RVALID is held with stable data until S_RREADY.
- Unmapped reads return 0 with RRESP SLVERR.
REQ-017 Reads and writes SHALL proceed concurrently; a read in the commit cycle returns the pre-commit value.
REQ-018 source_address, destination_address and length SHALL be driven directly from the SRC, DST and LEN registers.

Reset
REQ-019 While rst is high at a clock edge, all registers, holds and outputs SHALL go to 0, including:
- trigger, irq, S_BVALID, S_RVALID, S_AWREADY, S_WREADY, S_ARREADY.
REQ-020 The ready outputs SHALL rise in the first cycle after rst is deasserted.
REQ-021 Reset asserted mid-transaction SHALL abandon that transaction: no B or R beat is produced and no trigger is issued.

Structure
REQ-022 Shared package dma_pkg SHALL hold:
- register offsets;
- CTRL/STATUS bit positions;
- RESP_OKAY and RESP_SLVERR constants;
- the 5-bit length width shared with the DMA controller.
REQ-023 The block SHALL be a single module with no sub-module; the write-hold, read and status logic are small enough to stay flat.

Verification
REQ-024 Write SRC=0x0000_1003, DST=0x0000_2001, LEN=7 with WSTRB=4'hF, then read each back -> values match, RRESP=0 (OKAY).
REQ-025 Write CTRL=0x3 -> trigger high exactly one cycle at the commit edge; STATUS reads 0x1.
- Pulse dma_done -> STATUS reads 0x2 and irq=1.
- Write STATUS=0x2 -> STATUS reads 0x0 and irq=0.
REQ-026 While BUSY: write LEN=3 -> BRESP=2'b10 and LEN is unchanged.
- Write CTRL=0x1 -> no trigger, STATUS.REJECT=1, BRESP=0.
REQ-027 Present W three cycles before AW, with S_BREADY low for 4 cycles -> exactly one commit; S_BVALID held stable; no second write.
REQ-028 Write SRC=0xFFFF_FFFF, then write 0x0000_00AB with WSTRB=4'b0001 -> SRC reads 0xFFFF_FFAB.
- Read 0x18 -> RDATA=0, RRESP=2'b10.
REQ-029 Assert rst between the AW handshake and the W handshake -> no B beat and no trigger.
- After reset, all registers read 0 and a new write completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: register map, bit positions, response codes and length width shared by the DMA CSR block and controller
package dma_pkg;
  localparam int LEN_W = 5;
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_SRC    = 32'h08;
  localparam logic [31:0] OFF_DST    = 32'h0C;
  localparam logic [31:0] OFF_LEN    = 32'h10;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_REJECT = 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dma_csr.sv
// dma_csr: AXI-Lite register block holding the DMA job descriptor, start pulse, status and interrupt
module dma_csr
  import dma_pkg::*;
#(
  parameter int ADDR_LSB_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      S_AWADDR,
  input  logic             S_AWVALID,
  output logic             S_AWREADY,
  input  logic [31:0]      S_WDATA,
  input  logic [3:0]       S_WSTRB,
  input  logic             S_WVALID,
  output logic             S_WREADY,
  output logic [1:0]       S_BRESP,
  output logic             S_BVALID,
  input  logic             S_BREADY,
  input  logic [31:0]      S_ARADDR,
  input  logic             S_ARVALID,
  output logic             S_ARREADY,
  output logic [31:0]      S_RDATA,
  output logic [1:0]       S_RRESP,
  output logic             S_RVALID,
  input  logic             S_RREADY,
  output logic             trigger,
  output logic [31:0]      source_address,
  output logic [31:0]      destination_address,
  output logic [LEN_W-1:0] length,
  input  logic             dma_done,
  output logic             irq
);
  localparam int IW = ADDR_LSB_BITS - 2;
  function automatic logic hit(input logic [IW-1:0] idx, input logic [31:0] off);
    return idx == off[ADDR_LSB_BITS-1:2];
  endfunction
  logic rdy_en, aw_held, w_held, irq_en, busy, done, reject, dma_done_q;
  logic [IW-1:0] aw_idx, rd_idx;
  logic [31:0] w_data, src, dst, rd_val;
  logic [3:0] w_strb;
  logic [LEN_W-1:0] len;
  logic commit, wr_err, wr_ok, lane0, start, start_ok, done_rise, clr_done, clr_rej, rd_err;
  logic unused_addr;
  assign unused_addr = ^{S_AWADDR[31:ADDR_LSB_BITS], S_AWADDR[1:0], S_ARADDR[31:ADDR_LSB_BITS], S_ARADDR[1:0]};
  assign S_AWREADY = rdy_en & ~aw_held & ~S_BVALID;
  assign S_WREADY = rdy_en & ~w_held & ~S_BVALID;
  assign S_ARREADY = rdy_en & ~S_RVALID;
  assign source_address = src;
  assign destination_address = dst;
  assign length = len;
  assign irq = irq_en & done;
  assign commit = aw_held & w_held;
  assign lane0 = w_strb[0];
  assign rd_idx = S_ARADDR[ADDR_LSB_BITS-1:2];
  always_comb begin
    wr_err = ~(hit(aw_idx, OFF_CTRL) | hit(aw_idx, OFF_STATUS) | hit(aw_idx, OFF_SRC) | hit(aw_idx, OFF_DST) | hit(aw_idx, OFF_LEN))
           | (busy & (hit(aw_idx, OFF_SRC) | hit(aw_idx, OFF_DST) | hit(aw_idx, OFF_LEN)));
    wr_ok = commit & ~wr_err;
    start = wr_ok & hit(aw_idx, OFF_CTRL) & lane0 & w_data[CTRL_START];
    start_ok = start & ~busy;
    done_rise = dma_done & ~dma_done_q;
    clr_done = wr_ok & hit(aw_idx, OFF_STATUS) & lane0 & w_data[STAT_DONE];
    clr_rej = wr_ok & hit(aw_idx, OFF_STATUS) & lane0 & w_data[STAT_REJECT];
    rd_err = ~(hit(rd_idx, OFF_CTRL) | hit(rd_idx, OFF_STATUS) | hit(rd_idx, OFF_SRC) | hit(rd_idx, OFF_DST) | hit(rd_idx, OFF_LEN));
    rd_val = hit(rd_idx, OFF_CTRL)   ? 32'(irq_en) << CTRL_IRQ_EN :
             hit(rd_idx, OFF_STATUS) ? (32'(busy) << STAT_BUSY) | (32'(done) << STAT_DONE) | (32'(reject) << STAT_REJECT) :
             hit(rd_idx, OFF_SRC)    ? src :
             hit(rd_idx, OFF_DST)    ? dst :
             hit(rd_idx, OFF_LEN)    ? 32'(len) : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      S_BVALID <= 1'b0;
      S_BRESP <= RESP_OKAY;
      S_RVALID <= 1'b0;
      S_RDATA <= '0;
      S_RRESP <= RESP_OKAY;
      trigger <= 1'b0;
      irq_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      reject <= 1'b0;
      dma_done_q <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
    end else begin
      rdy_en <= 1'b1;
      dma_done_q <= dma_done;
      trigger <= start_ok;
      if (S_AWVALID & S_AWREADY) begin
        aw_held <= 1'b1;
        aw_idx <= S_AWADDR[ADDR_LSB_BITS-1:2];
      end
      if (S_WVALID & S_WREADY) begin
        w_held <= 1'b1;
        w_data <= S_WDATA;
        w_strb <= S_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_BVALID <= 1'b1;
        S_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_BREADY) begin
        S_BVALID <= 1'b0;
      end
      // a new start outranks a completion seen in the same cycle
      busy <= start_ok ? 1'b1 : done_rise ? 1'b0 : busy;
      done <= done_rise | (done & ~clr_done);
      reject <= (start & busy) | (reject & ~clr_rej);
      if (wr_ok & hit(aw_idx, OFF_CTRL) & lane0) irq_en <= w_data[CTRL_IRQ_EN];
      if (wr_ok & hit(aw_idx, OFF_SRC)) src <= merge_strb(src, w_data, w_strb);
      if (wr_ok & hit(aw_idx, OFF_DST)) dst <= merge_strb(dst, w_data, w_strb);
      if (wr_ok & hit(aw_idx, OFF_LEN) & lane0) len <= w_data[LEN_W-1:0];
      if (S_ARVALID & S_ARREADY) begin
        S_RVALID <= 1'b1;
        S_RDATA <= rd_val;
        S_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_RREADY) begin
        S_RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dma_csr.sv
// tb_dma_csr: directed self-checking bench for the DMA CSR block
module tb_dma_csr;
  logic clk = 0, rst = 1;
  logic [31:0] S_AWADDR = 0, S_WDATA = 0, S_ARADDR = 0, S_RDATA, source_address, destination_address;
  logic S_AWVALID = 0, S_WVALID = 0, S_BREADY = 0, S_ARVALID = 0, S_RREADY = 0, dma_done = 0;
  logic [3:0] S_WSTRB = 0;
  logic S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID, trigger, irq;
  logic [1:0] S_BRESP, S_RRESP;
  logic [4:0] length;
  int pass = 0, total = 0, trig_cnt = 0;

  dma_csr dut (
    .clk(clk), .rst(rst),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .trigger(trigger), .source_address(source_address), .destination_address(destination_address),
    .length(length), .dma_done(dma_done), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (trigger) trig_cnt++;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n;
    logic aw_go, w_go;
    @(negedge clk);
    S_AWADDR = a; S_AWVALID = 1; S_WDATA = d; S_WSTRB = s; S_WVALID = 1; S_BREADY = 1;
    n = 0;
    while ((S_AWVALID || S_WVALID) && n < 20) begin
      aw_go = S_AWVALID && S_AWREADY;
      w_go = S_WVALID && S_WREADY;
      @(negedge clk);
      n++;
      if (aw_go) S_AWVALID = 0;
      if (w_go) S_WVALID = 0;
    end
    S_AWVALID = 0; S_WVALID = 0;
    n = 0;
    while (!S_BVALID && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!S_BVALID) begin
      $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, S_BVALID);
      resp = 2'bxx;
    end else begin
      pass++;
      resp = S_BRESP;
    end
    @(negedge clk);
    S_BREADY = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    S_ARADDR = a; S_ARVALID = 1; S_RREADY = 1;
    n = 0;
    while (!S_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    S_ARVALID = 0;
    n = 0;
    while (!S_RVALID && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!S_RVALID) begin
      $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, S_RVALID);
      d = 'x; resp = 2'bxx;
    end else begin
      pass++;
      d = S_RDATA; resp = S_RRESP;
    end
    @(negedge clk);
    S_RREADY = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk); dma_done = 1;
    repeat (2) @(negedge clk);
    dma_done = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, trigger, irq} !== 7'b0)
      $display("FAIL reset_outputs got=%b required 0000000", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, trigger, irq});
    else pass++;
    total++;
    if ({source_address, destination_address, length} !== 69'b0)
      $display("FAIL reset_descriptor got=%h/%h/%h required 0", source_address, destination_address, length);
    else pass++;
    rst = 0;
    @(negedge clk);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111)
      $display("FAIL reset_ready_rise got=%b required 111", {S_AWREADY, S_WREADY, S_ARREADY});
    else pass++;
  endtask

  task automatic test_regs();
    logic [1:0] r;
    logic [31:0] d;
    wr(32'h08, 32'h0000_1003, 4'hF, r);
    total++; if (r !== 2'b00) $display("FAIL src_bresp got=%b required 00", r); else pass++;
    wr(32'h0C, 32'h0000_2001, 4'hF, r);
    total++; if (r !== 2'b00) $display("FAIL dst_bresp got=%b required 00", r); else pass++;
    wr(32'h10, 32'h0000_0007, 4'hF, r);
    total++; if (r !== 2'b00) $display("FAIL len_bresp got=%b required 00", r); else pass++;
    rd(32'h08, d, r);
    total++; if (d !== 32'h1003 || r !== 2'b00) $display("FAIL src_read got=%h/%b required 00001003/00", d, r); else pass++;
    rd(32'h0C, d, r);
    total++; if (d !== 32'h2001 || r !== 2'b00) $display("FAIL dst_read got=%h/%b required 00002001/00", d, r); else pass++;
    rd(32'h10, d, r);
    total++; if (d !== 32'h7 || r !== 2'b00) $display("FAIL len_read got=%h/%b required 00000007/00", d, r); else pass++;
    total++;
    if (source_address !== 32'h1003 || destination_address !== 32'h2001 || length !== 5'd7)
      $display("FAIL descriptor_ports got=%h/%h/%h required 00001003/00002001/07", source_address, destination_address, length);
    else pass++;
  endtask

  task automatic test_start_done();
    logic [1:0] r;
    logic [31:0] d;
    int t0;
    t0 = trig_cnt;
    wr(32'h00, 32'h3, 4'hF, r);
    total++; if (trig_cnt - t0 !== 1) $display("FAIL start_trigger_cycles got=%0d required 1", trig_cnt - t0); else pass++;
    rd(32'h04, d, r);
    total++; if (d !== 32'h1) $display("FAIL status_busy got=%h required 00000001", d); else pass++;
    rd(32'h00, d, r);
    total++; if (d !== 32'h2) $display("FAIL ctrl_read got=%h required 00000002", d); else pass++;
    pulse_done();
    rd(32'h04, d, r);
    total++; if (d !== 32'h2) $display("FAIL status_done got=%h required 00000002", d); else pass++;
    total++; if (irq !== 1'b1) $display("FAIL irq_set got=%b required 1", irq); else pass++;
    wr(32'h04, 32'h2, 4'hF, r);
    rd(32'h04, d, r);
    total++; if (d !== 32'h0) $display("FAIL status_w1c got=%h required 00000000", d); else pass++;
    total++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b required 0", irq); else pass++;
  endtask

  task automatic test_busy();
    logic [1:0] r;
    logic [31:0] d;
    int t0;
    t0 = trig_cnt;
    wr(32'h00, 32'h1, 4'hF, r);
    total++; if (trig_cnt - t0 !== 1) $display("FAIL busy_start_trigger got=%0d required 1", trig_cnt - t0); else pass++;
    wr(32'h10, 32'h3, 4'hF, r);
    total++; if (r !== 2'b10) $display("FAIL busy_len_bresp got=%b required 10", r); else pass++;
    rd(32'h10, d, r);
    total++; if (d !== 32'h7) $display("FAIL busy_len_kept got=%h required 00000007", d); else pass++;
    t0 = trig_cnt;
    wr(32'h00, 32'h1, 4'hF, r);
    total++; if (r !== 2'b00) $display("FAIL reject_bresp got=%b required 00", r); else pass++;
    total++; if (trig_cnt !== t0) $display("FAIL reject_no_trigger got=%0d required %0d", trig_cnt, t0); else pass++;
    wr(32'h04, 32'h1, 4'hF, r);
    rd(32'h04, d, r);
    total++; if (d !== 32'h5) $display("FAIL status_reject_busy got=%h required 00000005", d); else pass++;
    pulse_done();
    rd(32'h04, d, r);
    total++; if (d !== 32'h6) $display("FAIL status_after_done got=%h required 00000006", d); else pass++;
    total++; if (irq !== 1'b0) $display("FAIL irq_disabled got=%b required 0", irq); else pass++;
    wr(32'h04, 32'h6, 4'hF, r);
    rd(32'h04, d, r);
    total++; if (d !== 32'h0) $display("FAIL status_clear_all got=%h required 00000000", d); else pass++;
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    logic [31:0] d;
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, r);
    wr(32'h08, 32'h0000_00AB, 4'b0001, r);
    rd(32'h08, d, r);
    total++; if (d !== 32'hFFFF_FFAB) $display("FAIL strobe_lane0 got=%h required ffffffab", d); else pass++;
    rd(32'h18, d, r);
    total++; if (d !== 32'h0 || r !== 2'b10) $display("FAIL unmapped_read got=%h/%b required 00000000/10", d, r); else pass++;
    wr(32'h14, 32'h1234, 4'hF, r);
    total++; if (r !== 2'b10) $display("FAIL unmapped_write got=%b required 10", r); else pass++;
    wr(32'hFFFF_FFEF, 32'h1234_5678, 4'hF, r);
    rd(32'h0C, d, r);
    total++; if (d !== 32'h1234_5678) $display("FAIL addr_alias got=%h required 12345678", d); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    logic [31:0] d;
    int bad;
    @(negedge clk);
    S_BREADY = 0; S_WDATA = 32'h55; S_WSTRB = 4'hF; S_WVALID = 1;
    @(negedge clk);
    S_WVALID = 0;
    repeat (2) @(negedge clk);
    total++; if (S_WREADY !== 1'b0 || S_BVALID !== 1'b0) $display("FAIL w_held got=%b%b required 00", S_WREADY, S_BVALID); else pass++;
    S_AWADDR = 32'h08; S_AWVALID = 1;
    total++; if (S_AWREADY !== 1'b1) $display("FAIL aw_ready_while_w_held got=%b required 1", S_AWREADY); else pass++;
    @(negedge clk);
    S_AWVALID = 0;
    @(negedge clk);
    bad = 0;
    repeat (4) begin
      if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00) bad++;
      @(negedge clk);
    end
    total++; if (bad != 0) $display("FAIL bvalid_stable got=%0d_bad_cycles required 0", bad); else pass++;
    S_BREADY = 1;
    @(negedge clk);
    S_BREADY = 0;
    bad = 0;
    repeat (3) begin
      if (S_BVALID !== 1'b0) bad++;
      @(negedge clk);
    end
    total++; if (bad != 0) $display("FAIL single_commit got=%0d_extra_b_cycles required 0", bad); else pass++;
    rd(32'h08, d, r);
    total++; if (d !== 32'h55) $display("FAIL held_write_data got=%h required 00000055", d); else pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    logic [31:0] d;
    int t0, bad;
    t0 = trig_cnt;
    @(negedge clk);
    S_AWADDR = 32'h00; S_AWVALID = 1; S_BREADY = 1;
    @(negedge clk);
    S_AWVALID = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (S_BVALID !== 1'b0) bad++;
    end
    S_BREADY = 0;
    total++; if (bad != 0 || trig_cnt !== t0) $display("FAIL reset_abandon got=%0d_b/%0d_trig required 0/0", bad, trig_cnt - t0); else pass++;
    rd(32'h08, d, r);
    total++; if (d !== 32'h0) $display("FAIL reset_src got=%h required 00000000", d); else pass++;
    rd(32'h0C, d, r);
    total++; if (d !== 32'h0) $display("FAIL reset_dst got=%h required 00000000", d); else pass++;
    rd(32'h10, d, r);
    total++; if (d !== 32'h0) $display("FAIL reset_len got=%h required 00000000", d); else pass++;
    wr(32'h10, 32'h9, 4'hF, r);
    total++; if (r !== 2'b00) $display("FAIL post_reset_bresp got=%b required 00", r); else pass++;
    rd(32'h10, d, r);
    total++; if (d !== 32'h9) $display("FAIL post_reset_len got=%h required 00000009", d); else pass++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_start_done();
    test_busy();
    test_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
